ex_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the EX stage.
- Decides, every cycle, the write enables and flushes for PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use stalls, branch-mispredict redirect/flush, multi-cycle EX operations (start/done handshake with watchdog), and MEM-stage wait freezes.
- Keeps saturating stall/flush performance counters.

---
 rtl/ex_hazard_ctrl_pkg.sv | 17 +
 rtl/ex_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/ex_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg
// Shared types and default widths for the EX-stage hazard controller.
//   ctrl_state_e : controller mode, RUN (normal issue) or MC_WAIT
//                  (waiting on the multi-cycle unit)
//   DATA_W_DEF   : default data / PC width
//   REG_W_DEF    : default register index width
package ex_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } ctrl_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

endpackage

// File: rtl/ex_hazard_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock, counts on rising edge
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// EX-stage pipeline sequencing controller. Every cycle it produces the
// write enables and bubble (flush) controls for PC, IF/ID, ID/EX and
// EX/MEM, handling MEM-wait freezes, multi-cycle EX operations with a
// watchdog, branch-mispredict redirects and load-use stalls.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   id_rs1, id_rs2                 : source registers of the ID instruction
//   id_ex_rd, id_ex_mem_read       : destination / load flag of EX instruction
//   ex_is_branch, ex_predict,
//   ex_taken, ex_target, ex_pc_4   : branch resolution from the BRU
//   ex_mc_op, mc_done              : multi-cycle unit request / completion
//   mem_busy                       : MEM stage has not finished its access
//   pc_write .. ex_mem_flush       : pipeline register enables and bubbles
//   mc_start                       : start pulse to the multi-cycle unit
//   redirect, redirect_pc          : fetch redirect on mispredict
//   mc_timeout                     : sticky watchdog error
//   stall_cnt, flush_cnt           : saturating performance counters
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              ex_is_branch,
    input  logic              ex_predict,
    input  logic              ex_taken,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] ex_pc_4,
    input  logic              ex_mc_op,
    input  logic              mc_done,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic              ex_mem_flush,
    output logic              mc_start,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              mc_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // One spare bit so the watchdog can count past MC_TIMEOUT-1 while a
    // completion is being held behind mem_busy.
    localparam int                WDOG_W    = $clog2(MC_TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MC_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

    ctrl_state_e       state;
    logic [WDOG_W-1:0] wdog;
    logic              done_held;
    logic              mispredict;
    logic              load_use;
    logic              wdog_hit;
    logic              mc_finish;
    logic              stall_inc;

    assign mispredict = ex_is_branch && (ex_taken != ex_predict);
    assign load_use   = id_ex_mem_read && (id_ex_rd != '0) &&
                        ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

    // mc_done is only a one-cycle pulse, so a completion (real or forced by
    // the watchdog) that lands while MEM is busy is remembered in done_held
    // until the freeze lifts.
    assign wdog_hit  = (state == MC_WAIT) && !done_held && !mc_done &&
                       (wdog == WDOG_LAST);
    assign mc_finish = (state == MC_WAIT) && (mc_done || done_held || wdog_hit);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mc_start     = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state == RUN) begin
            if (mem_busy) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end else if (ex_mc_op) begin
                mc_start     = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (mispredict) begin
                redirect     = 1'b1;
                redirect_pc  = ex_taken ? ex_target : ex_pc_4;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_flush  = 1'b1;
            end
        end else begin
            if (mem_busy) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end else if (!mc_finish) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
            end
        end
    end

    // Controller state, watchdog and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wdog       <= '0;
            done_held  <= 1'b0;
            mc_timeout <= 1'b0;
        end else begin
            if (wdog_hit) begin
                mc_timeout <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (!mem_busy && ex_mc_op) begin
                        state     <= MC_WAIT;
                        wdog      <= '0;
                        done_held <= 1'b0;
                    end
                end
                MC_WAIT: begin
                    if (wdog != WDOG_MAX) begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                    if (mc_finish && !mem_busy) begin
                        state     <= RUN;
                        done_held <= 1'b0;
                    end else if (mc_finish) begin
                        done_held <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // A redirect cycle never has pc_write low, but the mask keeps the stall
    // count strictly about lost fetch cycles.
    assign stall_inc = !rst && !pc_write && !redirect;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl
// Self-checking bench for ex_hazard_ctrl: a table of single-cycle RUN
// vectors, hand-written multi-cycle sequences, then randomized traffic
// compared against a behavioural model of the controller.
module tb_ex_hazard_ctrl;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int CNT_W      = 4;
    localparam int MC_TIMEOUT = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // Flag order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_flush, ex_mem_write, ex_mem_flush, mc_start, redirect
    localparam logic [8:0] V_DEF     = 9'b110101000;
    localparam logic [8:0] V_STALL   = 9'b000111000;
    localparam logic [8:0] V_MISP    = 9'b111111001;
    localparam logic [8:0] V_FREEZE  = 9'b000000000;
    localparam logic [8:0] V_RST     = 9'b111111100;
    localparam logic [8:0] V_MCSTART = 9'b000001110;
    localparam logic [8:0] V_MCWAIT  = 9'b000001100;

    typedef struct {
        logic             rst;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             mem_read;
        logic             is_branch;
        logic             predict;
        logic             taken;
        logic [31:0]      target;
        logic [31:0]      pc4;
        logic             mc_op;
        logic             mc_done;
        logic             mem_busy;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [8:0]  flags;
        logic [31:0] pc;
        string       name;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_W-1:0]  id_rs1, id_rs2, id_ex_rd;
    logic              id_ex_mem_read, ex_is_branch, ex_predict, ex_taken;
    logic [DATA_W-1:0] ex_target, ex_pc_4;
    logic              ex_mc_op, mc_done, mem_busy;
    logic              pc_write, if_id_write, if_id_flush, id_ex_write;
    logic              id_ex_flush, ex_mem_write, ex_mem_flush, mc_start;
    logic              redirect, mc_timeout;
    logic [DATA_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic [8:0]        act_flags;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: are we waiting on the multi-cycle unit, how
    // many wait cycles have elapsed, is a completion parked behind mem_busy.
    bit m_wait, m_held, m_to;
    int m_waited, m_stall, m_flush;

    always #5 clk = ~clk;

    assign act_flags = {pc_write, if_id_write, if_id_flush, id_ex_write,
                        id_ex_flush, ex_mem_write, ex_mem_flush, mc_start, redirect};

    ex_hazard_ctrl #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .ex_is_branch(ex_is_branch),
        .ex_predict(ex_predict), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pc_4(ex_pc_4),
        .ex_mc_op(ex_mc_op), .mc_done(mc_done), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mc_start(mc_start), .redirect(redirect), .redirect_pc(redirect_pc),
        .mc_timeout(mc_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Branch and multi-cycle op together is illegal stimulus.
    always @(negedge clk) begin
        assert (!(ex_is_branch && ex_mc_op))
            else $error("[TB] illegal stimulus: ex_is_branch with ex_mc_op");
    end

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.mem_read = 1'b0; s.is_branch = 1'b0; s.predict = 1'b0; s.taken = 1'b0;
        s.target = '0; s.pc4 = '0; s.mc_op = 1'b0; s.mc_done = 1'b0; s.mem_busy = 1'b0;
        return s;
    endfunction

    function automatic stim_t loadStim(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs1,
                                       input logic [REG_W-1:0] rs2);
        stim_t s = idleStim();
        s.mem_read = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        return s;
    endfunction

    function automatic stim_t branchStim(input logic p, input logic t,
                                         input logic [31:0] tgt, input logic [31:0] pc4);
        stim_t s = idleStim();
        s.is_branch = 1'b1; s.predict = p; s.taken = t; s.target = tgt; s.pc4 = pc4;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_ex_rd = s.rd;
        id_ex_mem_read = s.mem_read; ex_is_branch = s.is_branch;
        ex_predict = s.predict; ex_taken = s.taken;
        ex_target = s.target; ex_pc_4 = s.pc4;
        ex_mc_op = s.mc_op; mc_done = s.mc_done; mem_busy = s.mem_busy;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] f, input logic [31:0] pc);
        checks++;
        if (act_flags !== f || redirect_pc !== pc) begin
            errors++;
            $display("[TB] FAIL %s: flags=%b pc=%h, expected flags=%b pc=%h",
                     name, act_flags, redirect_pc, f, pc);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs mid-cycle, then step to
    // 1ns past the next rising edge so registered outputs can be read.
    task automatic runCycle(input stim_t s, input logic [8:0] f,
                            input logic [31:0] pc, input string name);
        applyStimulus(s);
        @(negedge clk);
        checkOutput(name, f, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        stim_t s = idleStim();
        s.rst = 1'b1;
        runCycle(s, V_RST, 32'h0, "reset_outputs");
        checkValue("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        checkValue("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        checkValue("reset_mc_timeout", 32'(mc_timeout), 32'd0);
        m_wait = 0; m_held = 0; m_to = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    // Expected outputs from the controller rules for the current model state.
    function automatic void modelOutputs(input stim_t s, output logic [8:0] f,
                                         output logic [31:0] pc, output bit done_now,
                                         output bit tmo_now);
        f = V_DEF; pc = '0; done_now = 0; tmo_now = 0;
        if (s.rst) begin
            f = V_RST;
        end else if (!m_wait) begin
            if (s.mem_busy) f = V_FREEZE;
            else if (s.mc_op) f = V_MCSTART;
            else if (s.is_branch && (s.taken != s.predict)) begin
                f = V_MISP;
                pc = s.taken ? s.target : s.pc4;
            end else if (s.mem_read && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2))
                f = V_STALL;
        end else begin
            tmo_now = !m_held && !s.mc_done && (m_waited == MC_TIMEOUT - 1);
            done_now = m_held || s.mc_done || tmo_now;
            if (s.mem_busy) f = V_FREEZE;
            else if (done_now) f = V_DEF;
            else f = V_MCWAIT;
        end
    endfunction

    function automatic void modelUpdate(input stim_t s, input logic [8:0] f,
                                        input bit done_now, input bit tmo_now);
        if (s.rst) begin
            m_wait = 0; m_held = 0; m_to = 0; m_waited = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (!f[8] && !f[0] && m_stall < CNT_MAX) m_stall++;
        if (f[0] && m_flush < CNT_MAX) m_flush++;
        if (tmo_now) m_to = 1;
        if (!m_wait) begin
            if (!s.mem_busy && s.mc_op) begin
                m_wait = 1; m_waited = 0; m_held = 0;
            end
        end else begin
            m_waited++;
            if (done_now && !s.mem_busy) begin
                m_wait = 0; m_held = 0;
            end else if (done_now) begin
                m_held = 1;
            end
        end
    endfunction

    function automatic stim_t randStim();
        stim_t s = idleStim();
        s.rst      = ($urandom_range(0, 99) < 3);
        s.rs1      = REG_W'($urandom_range(0, 3));
        s.rs2      = REG_W'($urandom_range(0, 3));
        s.rd       = REG_W'($urandom_range(0, 3));
        s.mem_read = $urandom_range(0, 1) == 1;
        s.mc_op    = ($urandom_range(0, 9) == 0);
        s.is_branch = s.mc_op ? 1'b0 : ($urandom_range(0, 2) == 0);
        s.predict  = $urandom_range(0, 1) == 1;
        s.taken    = $urandom_range(0, 1) == 1;
        s.target   = $urandom;
        s.pc4      = $urandom;
        s.mc_done  = ($urandom_range(0, 99) < 15);
        s.mem_busy = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    initial begin
        vec_t  vecs[12];
        stim_t s;
        int    starts;

        applyStimulus(idleStim());
        @(posedge clk);
        #1;
        doReset();

        // Single-cycle RUN vectors; no mc_op so the controller stays in RUN.
        vecs[0]  = '{loadStim(5, 5, 0), V_STALL, 32'h0, "load_use_rs1"};
        vecs[1]  = '{loadStim(0, 0, 0), V_DEF, 32'h0, "load_x0_no_stall"};
        vecs[2]  = '{loadStim(7, 1, 7), V_STALL, 32'h0, "load_use_rs2"};
        vecs[3]  = '{loadStim(5, 6, 7), V_DEF, 32'h0, "load_no_match"};
        vecs[4]  = '{branchStim(0, 1, 32'h100, 32'h8), V_MISP, 32'h100, "misp_taken"};
        vecs[5]  = '{branchStim(1, 0, 32'h100, 32'h24), V_MISP, 32'h24, "misp_not_taken"};
        vecs[6]  = '{branchStim(1, 1, 32'h100, 32'h24), V_DEF, 32'h0, "correct_predict"};
        s = branchStim(0, 1, 32'h200, 32'h4); s.mem_read = 1; s.rd = 3; s.rs1 = 3;
        vecs[7]  = '{s, V_MISP, 32'h200, "misp_over_load_use"};
        s = branchStim(0, 1, 32'h200, 32'h4); s.mem_busy = 1;
        vecs[8]  = '{s, V_FREEZE, 32'h0, "busy_over_misp"};
        s = idleStim(); s.predict = 0; s.taken = 1; s.target = 32'h300;
        vecs[9]  = '{s, V_DEF, 32'h0, "non_branch_outcome"};
        s = loadStim(4, 4, 4); s.mem_busy = 1;
        vecs[10] = '{s, V_FREEZE, 32'h0, "busy_over_load_use"};
        s = idleStim(); s.mc_done = 1;
        vecs[11] = '{s, V_DEF, 32'h0, "stray_mc_done_in_run"};
        for (int i = 0; i < 12; i++) begin
            runCycle(vecs[i].s, vecs[i].flags, vecs[i].pc, vecs[i].name);
        end

        // Load-use: one bubble, then defaults once the bubble reaches EX.
        doReset();
        runCycle(loadStim(5, 5, 0), V_STALL, 32'h0, "seq1_stall");
        runCycle(idleStim(), V_DEF, 32'h0, "seq1_after");
        checkValue("seq1_stall_cnt", 32'(stall_cnt), 32'd1);

        doReset();
        runCycle(loadStim(0, 0, 0), V_DEF, 32'h0, "seq2_x0");
        checkValue("seq2_stall_cnt", 32'(stall_cnt), 32'd0);

        // Mispredicts in both directions bump flush_cnt.
        doReset();
        runCycle(branchStim(0, 1, 32'h100, 32'h8), V_MISP, 32'h100, "seq3_taken");
        checkValue("seq3_flush_cnt_1", 32'(flush_cnt), 32'd1);
        runCycle(branchStim(1, 0, 32'h100, 32'h24), V_MISP, 32'h24, "seq3_not_taken");
        checkValue("seq3_flush_cnt_2", 32'(flush_cnt), 32'd2);
        checkValue("seq3_stall_cnt", 32'(stall_cnt), 32'd0);

        // Multi-cycle op, done on the 6th wait cycle: 6 cycles of pc_write=0.
        doReset();
        starts = 0;
        s = idleStim(); s.mc_op = 1;
        applyStimulus(s); @(negedge clk); starts += int'(mc_start);
        checkOutput("seq4_start", V_MCSTART, 32'h0); @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(s); @(negedge clk); starts += int'(mc_start);
            checkOutput("seq4_wait", V_MCWAIT, 32'h0); @(posedge clk); #1;
        end
        s.mc_done = 1;
        applyStimulus(s); @(negedge clk); starts += int'(mc_start);
        checkOutput("seq4_done", V_DEF, 32'h0); @(posedge clk); #1;
        s = idleStim();
        applyStimulus(s); @(negedge clk); starts += int'(mc_start);
        checkOutput("seq4_resume", V_DEF, 32'h0); @(posedge clk); #1;
        checkValue("seq4_mc_start_count", 32'(starts), 32'd1);
        checkValue("seq4_stall_cnt", 32'(stall_cnt), 32'd6);
        runCycle(loadStim(2, 2, 0), V_STALL, 32'h0, "seq4_back_in_run");

        // Watchdog: no mc_done, forced completion on the 8th wait cycle.
        doReset();
        s = idleStim(); s.mc_op = 1;
        runCycle(s, V_MCSTART, 32'h0, "seq5_start");
        for (int i = 1; i < MC_TIMEOUT; i++) begin
            runCycle(s, V_MCWAIT, 32'h0, "seq5_wait");
        end
        checkValue("seq5_no_timeout_yet", 32'(mc_timeout), 32'd0);
        runCycle(s, V_DEF, 32'h0, "seq5_forced_done");
        checkValue("seq5_timeout_set", 32'(mc_timeout), 32'd1);
        checkValue("seq5_stall_cnt", 32'(stall_cnt), 32'd8);
        runCycle(idleStim(), V_DEF, 32'h0, "seq5_run");
        runCycle(loadStim(6, 0, 6), V_STALL, 32'h0, "seq5_run_stall");
        checkValue("seq5_timeout_sticky", 32'(mc_timeout), 32'd1);
        doReset();

        // MEM freeze holds a mispredict until mem_busy falls.
        s = branchStim(0, 1, 32'h100, 32'h8); s.mem_busy = 1;
        for (int i = 0; i < 3; i++) runCycle(s, V_FREEZE, 32'h0, "seq6_frozen");
        checkValue("seq6_flush_while_busy", 32'(flush_cnt), 32'd0);
        s.mem_busy = 0;
        runCycle(s, V_MISP, 32'h100, "seq6_redirect");
        runCycle(idleStim(), V_DEF, 32'h0, "seq6_after");
        checkValue("seq6_flush_cnt", 32'(flush_cnt), 32'd1);
        checkValue("seq6_stall_cnt", 32'(stall_cnt), 32'd3);

        // Completion arriving under mem_busy is held until the freeze ends.
        doReset();
        s = idleStim(); s.mc_op = 1;
        runCycle(s, V_MCSTART, 32'h0, "hold_start");
        runCycle(s, V_MCWAIT, 32'h0, "hold_wait");
        s.mc_done = 1; s.mem_busy = 1;
        runCycle(s, V_FREEZE, 32'h0, "hold_done_busy");
        s.mc_done = 0;
        runCycle(s, V_FREEZE, 32'h0, "hold_still_busy");
        s.mem_busy = 0;
        runCycle(s, V_DEF, 32'h0, "hold_release");
        runCycle(loadStim(9, 9, 0), V_STALL, 32'h0, "hold_back_in_run");

        // Reset while waiting abandons the op; a late mc_done is ignored.
        doReset();
        runCycle(loadStim(5, 5, 0), V_STALL, 32'h0, "rstwait_stall");
        runCycle(branchStim(1, 0, 32'h0, 32'h40), V_MISP, 32'h40, "rstwait_misp");
        s = idleStim(); s.mc_op = 1;
        runCycle(s, V_MCSTART, 32'h0, "rstwait_start");
        runCycle(s, V_MCWAIT, 32'h0, "rstwait_wait1");
        runCycle(s, V_MCWAIT, 32'h0, "rstwait_wait2");
        checkValue("rstwait_stall_before", 32'(stall_cnt), 32'd4);
        checkValue("rstwait_flush_before", 32'(flush_cnt), 32'd1);
        doReset();
        s = idleStim(); s.mc_done = 1;
        runCycle(s, V_DEF, 32'h0, "rstwait_late_done");
        checkValue("rstwait_stall_after", 32'(stall_cnt), 32'd0);

        // stall_cnt sticks at all-ones.
        doReset();
        for (int i = 0; i < CNT_MAX + 5; i++) runCycle(loadStim(1, 1, 1), V_STALL, 32'h0, "sat_stall");
        checkValue("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

        // Randomized traffic against the behavioural model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [8:0]  ef;
            logic [31:0] ep;
            bit          dn, tm;
            stim_t       rs;
            rs = randStim();
            modelOutputs(rs, ef, ep, dn, tm);
            runCycle(rs, ef, ep, "rand_outputs");
            modelUpdate(rs, ef, dn, tm);
            checkValue("rand_stall_cnt", 32'(stall_cnt), 32'(m_stall));
            checkValue("rand_flush_cnt", 32'(flush_cnt), 32'(m_flush));
            checkValue("rand_mc_timeout", 32'(mc_timeout), 32'(m_to));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
